hamming_enc_engine: RTL and testbench

Hardware Hamming(16,11) encode engine that sits directly upstream of the single-port data memory and owns its address, write-enable, read-enable and write-data inputs while active. On `Start` it walks `COUNT` 11-bit messages stored as byte pairs at `SRC_BASE` and encodes each with SECDED parity. It writes the 16-bit codewords as byte pairs at `DST_BASE`, then pulses `Done`. The processor core holds off memory access while `Busy` is high.

---
 rtl/hamming_pkg.sv | 36 +++
 rtl/hamming_enc_engine_if.sv | 21 ++
 rtl/hamming_parity_gen.sv | 11 +
 rtl/hamming_enc_engine.sv | 107 ++++++++++
 tb/tb_hamming_enc_engine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(16,11) SECDED definitions: FSM state type, codeword bit positions
// and the reference encode function, reused by the encode and decode stages.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    FIN
  } enc_state_t;

  // Parity bit positions inside the 16-bit codeword; data fills the rest.
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  // m[0] is b1, m[10] is b11.
  function automatic logic [15:0] hamming_encode(input logic [10:0] m);
    logic [15:0] cw;
    cw          = '0;
    cw[15:9]    = m[10:4];
    cw[7:5]     = m[3:1];
    cw[3]       = m[0];
    cw[POS_P8]  = ^m[10:4];
    cw[POS_P4]  = ^{m[10:7], m[3:1]};
    cw[POS_P2]  = ^{m[10], m[9], m[6], m[5], m[3], m[2], m[0]};
    cw[POS_P1]  = ^{m[10], m[8], m[6], m[4], m[3], m[1], m[0]};
    cw[POS_P0]  = ^cw[15:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_enc_engine_if.sv
// Single-port data memory bus; the engine is master, the memory is slave.
interface hamming_enc_engine_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
);
  logic [A-1:0] MemAddr;
  logic         MemRdEn;
  logic         MemWrEn;
  logic [W-1:0] MemWrData;
  logic [W-1:0] MemRdData;

  modport master (
    output MemAddr, MemRdEn, MemWrEn, MemWrData,
    input  MemRdData
  );

  modport slave (
    input  MemAddr, MemRdEn, MemWrEn, MemWrData,
    output MemRdData
  );
endinterface

// File: rtl/hamming_parity_gen.sv
// Purely combinational Hamming(16,11) SECDED encoder: 11-bit message in, codeword out.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [10:0] msg,
  output logic [15:0] codeword
);

  assign codeword = hamming_encode(msg);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-to-memory Hamming(16,11) encode engine: reads COUNT byte-pair messages at
// SRC_BASE, writes byte-pair codewords at DST_BASE, then pulses Done.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned A        = 8,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30,
  parameter int unsigned COUNT    = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  hamming_enc_engine_if.master mem
);

  localparam logic [A-1:0] SRC  = A'(SRC_BASE);
  localparam logic [A-1:0] DST  = A'(DST_BASE);
  localparam logic [A-1:0] LAST = A'(COUNT - 1);

  enc_state_t   state;
  enc_state_t   state_next;
  logic [A-1:0] idx;
  logic [A-1:0] offs;
  logic [7:0]   lo_q;
  logic [2:0]   hi_q;
  logic [15:0]  cw;

  // Address arithmetic is A bits wide, so base + offset wraps modulo 2**A.
  assign offs = idx << 1;

  hamming_parity_gen u_parity (
    .msg      ({hi_q, lo_q}),
    .codeword (cw)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx  <= '0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      case (state)
        IDLE:    if (Start) idx <= '0;
        RD_LO:   lo_q <= mem.MemRdData[7:0];
        RD_HI:   hi_q <= mem.MemRdData[2:0];
        WR_HI:   if (idx != LAST) idx <= idx + A'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RD_LO;
      RD_LO:   state_next = RD_HI;
      RD_HI:   state_next = WR_LO;
      WR_LO:   state_next = WR_HI;
      WR_HI:   state_next = (idx == LAST) ? FIN : RD_LO;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    mem.MemAddr   = '0;
    mem.MemRdEn   = 1'b0;
    mem.MemWrEn   = 1'b0;
    mem.MemWrData = '0;
    Busy          = (state != IDLE);
    Done          = (state == FIN);
    case (state)
      RD_LO: begin
        mem.MemAddr = SRC + offs;
        mem.MemRdEn = 1'b1;
      end
      RD_HI: begin
        mem.MemAddr = SRC + offs + A'(1);
        mem.MemRdEn = 1'b1;
      end
      WR_LO: begin
        mem.MemAddr   = DST + offs;
        mem.MemWrEn   = 1'b1;
        mem.MemWrData = cw[7:0];
      end
      WR_HI: begin
        mem.MemAddr   = DST + offs + A'(1);
        mem.MemWrEn   = 1'b1;
        mem.MemWrData = cw[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Self-checking bench: two engines (COUNT=1 and COUNT=15) on private memories,
// compared against a position-based Hamming model.
module tb_hamming_enc_engine;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;
  logic clr;

  hamming_enc_engine_if #(.W(8), .A(8)) bus_a ();
  hamming_enc_engine_if #(.W(8), .A(8)) bus_b ();

  hamming_enc_engine #(.W(8), .A(8), .SRC_BASE(0), .DST_BASE(30), .COUNT(1)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .Start(start_a), .Busy(busy_a), .Done(done_a), .mem(bus_a)
  );

  hamming_enc_engine #(.W(8), .A(8), .SRC_BASE(0), .DST_BASE(30), .COUNT(15)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Start(start_b), .Busy(busy_b), .Done(done_b), .mem(bus_b)
  );

  // Source bytes are written only by the stimulus; destination bytes only by the DUT.
  logic [7:0] src_a [256];
  logic [7:0] src_b [256];
  logic [7:0] dst_a [256];
  logic [7:0] dst_b [256];

  assign bus_a.MemRdData = src_a[bus_a.MemAddr];
  assign bus_b.MemRdData = src_b[bus_b.MemAddr];

  always @(posedge Clk) begin
    if (clr) begin
      for (int k = 0; k < 256; k++) begin
        dst_a[k] <= 8'hA5;
        dst_b[k] <= 8'hA5;
      end
    end else begin
      if (bus_a.MemWrEn) dst_a[bus_a.MemAddr] <= bus_a.MemWrData;
      if (bus_b.MemWrEn) dst_b[bus_b.MemAddr] <= bus_b.MemWrData;
    end
  end

  int conflicts = 0;
  always @(negedge Clk) begin
    if ((bus_a.MemRdEn && bus_a.MemWrEn) || (bus_b.MemRdEn && bus_b.MemWrEn))
      conflicts <= conflicts + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  // Data bits fill the non-power-of-two positions in order; parity bit p covers
  // every position whose index has bit p set; bit 0 makes the whole word even.
  function automatic logic [15:0] ref_encode(input logic [10:0] msg);
    logic [15:0] cw;
    int k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = msg[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      for (int pos = 1; pos < 16; pos++)
        if (((pos & p) != 0) && (pos != p)) cw[p] = cw[p] ^ cw[pos];
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic clear_mem();
    clr = 1'b1;
    @(negedge Clk);
    clr = 1'b0;
  endtask

  // Start pulse in cycle 0; cycle c is observed at the negedge inside it.
  // poke >= 1 re-asserts Start for that one cycle mid-run.
  task automatic run(input bit sel, input int poke,
                     output int done_cyc, output int done_n, output int busy_n);
    logic b, d;
    done_cyc = -1;
    done_n   = 0;
    busy_n   = 0;
    @(negedge Clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge Clk);
    if (sel) start_b = 1'b0; else start_a = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (b) busy_n++;
      if (d) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 6) break;
      if (sel) start_b = (c + 1 == poke); else start_a = (c + 1 == poke);
      @(negedge Clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  logic [10:0] dmsg [4] = '{11'h000, 11'h7FF, 11'h001, 11'h400};
  logic [7:0]  dlo  [4] = '{8'h00, 8'hFF, 8'h0F, 8'h17};
  logic [7:0]  dhi  [4] = '{8'h00, 8'hFF, 8'h00, 8'h81};
  logic [10:0] rmsg [15];

  initial begin
    int dc, dn, bn;
    logic [15:0] cw;

    Reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    clr     = 1'b1;
    for (int k = 0; k < 256; k++) begin
      src_a[k] = 8'h00;
      src_b[k] = 8'h00;
    end
    repeat (2) @(negedge Clk);
    check("reset_busy", {30'd0, busy_a, busy_b}, 32'd0);
    check("reset_done", {30'd0, done_a, done_b}, 32'd0);
    Reset = 1'b0;
    clr   = 1'b0;
    @(negedge Clk);
    check("idle_addr", {16'd0, bus_a.MemAddr, bus_b.MemAddr}, 32'd0);
    check("idle_en", {28'd0, bus_a.MemRdEn, bus_a.MemWrEn, bus_b.MemRdEn, bus_b.MemWrEn}, 32'd0);
    check("idle_wdata", {16'd0, bus_a.MemWrData, bus_b.MemWrData}, 32'd0);

    // Directed single-message runs.
    for (int v = 0; v < 4; v++) begin
      src_a[0] = dmsg[v][7:0];
      src_a[1] = {5'b00000, dmsg[v][10:8]};
      clear_mem();
      run(1'b0, 0, dc, dn, bn);
      cw = ref_encode(dmsg[v]);
      check($sformatf("dir%0d_lsw", v), {24'd0, dst_a[30]}, {24'd0, dlo[v]});
      check($sformatf("dir%0d_msw", v), {24'd0, dst_a[31]}, {24'd0, dhi[v]});
      check($sformatf("dir%0d_model", v), {16'd0, dst_a[31], dst_a[30]}, {16'd0, cw});
      check($sformatf("dir%0d_done_cyc", v), dc, 32'd5);
      check($sformatf("dir%0d_done_n", v), dn, 32'd1);
      check($sformatf("dir%0d_busy_n", v), bn, 32'd5);
      check($sformatf("dir%0d_no_stray", v), {24'd0, dst_a[32]}, 32'hA5);
    end

    // Full random run; ignored MSW bits are all ones.
    for (int i = 0; i < 15; i++) begin
      rmsg[i]        = 11'($urandom);
      src_b[2*i]     = rmsg[i][7:0];
      src_b[2*i + 1] = {5'b11111, rmsg[i][10:8]};
    end
    clear_mem();
    run(1'b1, 0, dc, dn, bn);
    for (int i = 0; i < 15; i++) begin
      cw = ref_encode(rmsg[i]);
      check($sformatf("rnd%0d_lsw", i), {24'd0, dst_b[30 + 2*i]}, {24'd0, cw[7:0]});
      check($sformatf("rnd%0d_msw", i), {24'd0, dst_b[31 + 2*i]}, {24'd0, cw[15:8]});
    end
    check("rnd_busy_n", bn, 32'd61);
    check("rnd_done_cyc", dc, 32'd61);
    check("rnd_done_n", dn, 32'd1);

    // Start during WR_LO of message 0 must not restart the run.
    clear_mem();
    run(1'b1, 3, dc, dn, bn);
    check("poke_done_cyc", dc, 32'd61);
    check("poke_done_n", dn, 32'd1);
    check("poke_busy_n", bn, 32'd61);
    cw = ref_encode(rmsg[14]);
    check("poke_last", {16'd0, dst_b[59], dst_b[58]}, {16'd0, cw});

    // Reset in RD_HI of message 3 (cycle 14).
    clear_mem();
    dn = 0;
    @(negedge Clk);
    start_b = 1'b1;
    @(negedge Clk);
    start_b = 1'b0;
    repeat (13) begin
      if (done_b) dn++;
      @(negedge Clk);
    end
    check("rst_pre_addr", {24'd0, bus_b.MemAddr}, 32'd7);
    check("rst_pre_rden", {31'd0, bus_b.MemRdEn}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_busy", {31'd0, busy_b}, 32'd0);
    check("rst_done", {31'd0, done_b}, 32'd0);
    check("rst_addr", {24'd0, bus_b.MemAddr}, 32'd0);
    check("rst_en", {30'd0, bus_b.MemRdEn, bus_b.MemWrEn}, 32'd0);
    check("rst_wdata", {24'd0, bus_b.MemWrData}, 32'd0);
    Reset = 1'b0;
    repeat (10) begin
      if (done_b || busy_b) dn++;
      @(negedge Clk);
    end
    check("rst_no_done", dn, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cw = ref_encode(rmsg[i]);
      check($sformatf("rst_kept%0d", i), {16'd0, dst_b[31 + 2*i], dst_b[30 + 2*i]}, {16'd0, cw});
    end
    check("rst_untouched36", {24'd0, dst_b[36]}, 32'hA5);
    check("rst_untouched37", {24'd0, dst_b[37]}, 32'hA5);

    check("rd_wr_conflicts", conflicts, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
